// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, the byte receiver and the host.
// The controller is the slave side; the master side drives the receiver flag/data and the host controls.
interface uart_rx_ctrl_if #(
   parameter int unsigned CNT_W = 4
);
   logic             rx_en;
   logic             en_clk;
   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             rx_ready_clr;
   logic [7:0]       dout;
   logic             dout_valid;
   logic             dout_pop;
   logic [CNT_W-1:0] count;
   logic             overrun;
   logic             overrun_clr;

   modport master (
      output rx_en, rx_ready, rx_data, dout_pop, overrun_clr,
      input  en_clk, rx_ready_clr, dout, dout_valid, count, overrun
   );

   modport slave (
      input  rx_en, rx_ready, rx_data, dout_pop, overrun_clr,
      output en_clk, rx_ready_clr, dout, dout_valid, count, overrun
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, byte acknowledge FSM and
// first-word-fall-through receive FIFO with sticky overrun.
//
// state    | meaning
// ST_IDLE  | waiting for the receiver ready flag; captures the byte when it is seen
// ST_ACK   | rx_ready_clr high for one cycle while the receiver drops its flag
module uart_rx_ctrl #(
   parameter int unsigned CLK_DIV = 27,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_ctrl_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   state_t           state_q;
   logic [15:0]      div_q;
   logic             en_clk_q;
   logic             rx_ready_clr_q;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overrun_q, overrun_d;

   logic             push;
   logic             full;
   logic             accept;
   logic             drop;
   logic             pop;

   // Counter restarts from zero whenever rx_en is low, so the first tick is always CLK_DIV cycles out.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         en_clk_q <= 1'b0;
      end else if (!bus.rx_en) begin
         div_q    <= '0;
         en_clk_q <= 1'b0;
      end else if (div_q == 16'(CLK_DIV - 1)) begin
         div_q    <= '0;
         en_clk_q <= 1'b1;
      end else begin
         div_q    <= div_q + 16'd1;
         en_clk_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rx_ready_clr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.rx_ready) begin
                  state_q        <= ST_ACK;
                  rx_ready_clr_q <= 1'b1;
               end else begin
                  rx_ready_clr_q <= 1'b0;
               end
            end
            ST_ACK: begin
               state_q        <= ST_IDLE;
               rx_ready_clr_q <= 1'b0;
            end
            default: begin
               state_q        <= ST_IDLE;
               rx_ready_clr_q <= 1'b0;
            end
         endcase
      end
   end

   // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push into a full FIFO.
   always_comb begin
      push   = (state_q == ST_IDLE) && bus.rx_ready;
      full   = (count_q == CNT_W'(DEPTH));
      accept = push && !full;
      drop   = push && full;
      pop    = bus.dout_pop && (count_q != '0);

      wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      overrun_d = overrun_q;
      if (drop) begin
         overrun_d = 1'b1;
      end else if (bus.overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         mem_q[wr_ptr_q] <= bus.rx_data;
      end
   end

   assign bus.en_clk       = en_clk_q;
   assign bus.rx_ready_clr = rx_ready_clr_q;
   assign bus.dout         = mem_q[rd_ptr_q];
   assign bus.dout_valid   = (count_q != '0);
   assign bus.count        = count_q;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick timing, byte acknowledge, FIFO ordering,
// full/overrun behaviour and reset during acknowledge, checked against a byte queue.
module tb_uart_rx_ctrl;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned CNT_W   = 4;

   logic clk;
   logic rst;

   uart_rx_ctrl_if #(.CNT_W(CNT_W)) bus ();

   uart_rx_ctrl #(
      .CLK_DIV (CLK_DIV),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] sb [$];
   logic       exp_ovr    = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish (observed=timeout required=finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; presents one byte for a cycle, optionally with a pop and overrun_clr.
   task automatic send_byte(input logic [7:0] b, input bit pop, input bit clr);
      bit was_full;
      was_full = (sb.size() == DEPTH);
      if (pop && sb.size() > 0) begin
         chk("pre_pop_valid", bus.dout_valid, 1);
         chk("pre_pop_dout", bus.dout, sb[0]);
      end
      bus.rx_ready    = 1'b1;
      bus.rx_data     = b;
      bus.dout_pop    = pop;
      bus.overrun_clr = clr;
      if (pop && sb.size() > 0) void'(sb.pop_front());
      if (was_full) exp_ovr = 1'b1;
      else begin
         sb.push_back(b);
         if (clr) exp_ovr = 1'b0;
      end
      @(negedge clk);
      chk("ack_pulse", bus.rx_ready_clr, 1);
      chk("count_after_push", bus.count, sb.size());
      chk("overrun_after_push", bus.overrun, exp_ovr);
      if (sb.size() > 0) chk("head_after_push", bus.dout, sb[0]);
      bus.dout_pop    = 1'b0;
      bus.overrun_clr = 1'b0;
      bus.rx_ready    = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", bus.rx_ready_clr, 0);
      chk("count_in_ack", bus.count, sb.size());
   endtask

   task automatic pop_one();
      if (sb.size() == 0) begin
         chk("empty_valid", bus.dout_valid, 0);
         bus.dout_pop = 1'b1;
         @(negedge clk);
         bus.dout_pop = 1'b0;
         chk("empty_pop_count", bus.count, 0);
         chk("empty_pop_valid", bus.dout_valid, 0);
      end else begin
         chk("pop_valid", bus.dout_valid, 1);
         chk("pop_order", bus.dout, sb[0]);
         void'(sb.pop_front());
         bus.dout_pop = 1'b1;
         @(negedge clk);
         bus.dout_pop = 1'b0;
         chk("pop_count", bus.count, sb.size());
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.rx_en       = 1'b0;
      bus.rx_ready    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.dout_pop    = 1'b0;
      bus.overrun_clr = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_en_clk", bus.en_clk, 0);
      chk("rst_ack", bus.rx_ready_clr, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_valid", bus.dout_valid, 0);
      chk("rst_overrun", bus.overrun, 0);

      // Tick generator.
      rst       = 1'b0;
      bus.rx_en = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk($sformatf("tick_c%0d", c), bus.en_clk, (c % 4 == 0));
      end
      bus.rx_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("tick_disabled", bus.en_clk, 0);
      end
      bus.rx_en = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("tick_restart_c%0d", c), bus.en_clk, (c == 4));
      end
      bus.rx_en = 1'b0;
      @(negedge clk);

      // Single byte, then pops including one on empty.
      send_byte(8'hA5, 1'b0, 1'b0);
      pop_one();
      pop_one();

      // Fill to full, drop the ninth, drain in order, clear overrun.
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
      chk("full_count", bus.count, DEPTH);
      send_byte(8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) pop_one();
      pop_one();
      bus.overrun_clr = 1'b1;
      @(negedge clk);
      bus.overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      chk("overrun_cleared", bus.overrun, 0);

      // Full with a same-cycle pop still drops; set beats clear.
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
      send_byte(8'hFE, 1'b1, 1'b0);
      send_byte(8'h20, 1'b0, 1'b0);
      send_byte(8'hEE, 1'b0, 1'b1);
      chk("set_beats_clear", bus.overrun, 1);
      bus.overrun_clr = 1'b1;
      @(negedge clk);
      bus.overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      chk("overrun_cleared2", bus.overrun, 0);
      while (sb.size() > 0) pop_one();

      // Wrap with concurrent pops.
      for (int i = 0; i < 20; i++) begin
         send_byte(8'h40 + 8'(i), (sb.size() > 0), 1'b0);
         chk("wrap_count_le2", (bus.count <= 2), 1);
      end
      while (sb.size() > 0) pop_one();
      chk("wrap_overrun", bus.overrun, 0);

      // Reset while acknowledging; a flag still high afterwards is captured from IDLE.
      bus.rx_ready = 1'b1;
      bus.rx_data  = 8'h77;
      @(negedge clk);
      chk("pre_rst_ack", bus.rx_ready_clr, 1);
      rst         = 1'b1;
      bus.rx_data = 8'h5A;
      @(negedge clk);
      sb.delete();
      exp_ovr = 1'b0;
      chk("rst_ack_drop", bus.rx_ready_clr, 0);
      chk("rst_mid_count", bus.count, 0);
      chk("rst_mid_valid", bus.dout_valid, 0);
      chk("rst_mid_overrun", bus.overrun, 0);
      rst = 1'b0;
      sb.push_back(8'h5A);
      @(negedge clk);
      chk("post_rst_ack", bus.rx_ready_clr, 1);
      chk("post_rst_count", bus.count, 1);
      chk("post_rst_dout", bus.dout, sb[0]);
      bus.rx_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_ack_end", bus.rx_ready_clr, 0);
      pop_one();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
